// File: rtl/fd_pkg.sv
// Shared fetch/decode types: text base, nop encoding and the queued {pc, instr} entry.
package fd_pkg;

   localparam logic [31:0] PC_BASE_DEF = 32'h00003000;
   localparam logic [31:0] NOP_INSTR   = 32'h0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fd_queue_mem.sv
// DEPTH x 64-bit entry storage: synchronous write, registered read of next-cycle head.
// Latency 1 cycle; a write to the address being read is forwarded into the read register.
module fd_queue_mem
   import fd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  fq_entry_t       wdata,
   input  logic [AW-1:0]   raddr,
   output fq_entry_t       rdata
);

   fq_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      // Write-first so an entry landing in an empty queue is at the head next cycle.
      if (we && (waddr == raddr)) begin
         rdata <= wdata;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/fd_fetch_queue.sv
// Fetch-to-decode queue: 1-cycle latency (0 with FD_FETCH_QUEUE_BYPASS_EN defined and queue empty);
// backpressure to fetch via pc_wr_en = ~full | flush, independent of d_ready.
module fd_fetch_queue
   import fd_pkg::*;
#(
   parameter int          DEPTH   = 4,
   parameter logic [31:0] PC_BASE = PC_BASE_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              f_pc,
   input  logic [31:0]              f_instr,
   output logic                     pc_wr_en,
   input  logic                     flush,
   output logic                     d_valid,
   input  logic                     d_ready,
   output logic [31:0]              d_pc,
   output logic [31:0]              d_instr,
   output logic [31:0]              d_pc_off,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
   logic [CW-1:0] occ, occ_nxt;
   logic          full, empty, enq, deq, byp;
   fq_entry_t     head, wentry;

   assign full     = (occ == CW'(DEPTH));
   assign empty    = (occ == '0);
   assign pc_wr_en = ~full | flush;

`ifdef FD_FETCH_QUEUE_BYPASS_EN
   assign byp = empty & ~flush & d_ready;
`else
   assign byp = 1'b0;
`endif

   assign enq = pc_wr_en & ~flush & ~byp;
   assign deq = ~empty & d_ready & ~flush;

   always_comb begin
      rd_ptr_nxt = rd_ptr;
      wr_ptr_nxt = wr_ptr;
      occ_nxt    = occ;
      if (flush) begin
         rd_ptr_nxt = '0;
         wr_ptr_nxt = '0;
         occ_nxt    = '0;
      end else begin
         if (enq) wr_ptr_nxt = wr_ptr + AW'(1);
         if (deq) rd_ptr_nxt = rd_ptr + AW'(1);
         if (enq && !deq)      occ_nxt = occ + CW'(1);
         else if (deq && !enq) occ_nxt = occ - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         rd_ptr <= rd_ptr_nxt;
         wr_ptr <= wr_ptr_nxt;
         occ    <= occ_nxt;
      end
   end

   assign wentry = '{pc: f_pc, instr: f_instr};

   // Read address is the next head pointer, so the storage output register holds the head.
   fd_queue_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (enq & ~reset),
      .waddr (wr_ptr),
      .wdata (wentry),
      .raddr (rd_ptr_nxt),
      .rdata (head)
   );

   always_comb begin
      d_valid = ~empty;
      d_pc    = 32'h0;
      d_instr = NOP_INSTR;
      if (byp) begin
         d_valid = 1'b1;
         d_pc    = f_pc;
         d_instr = f_instr;
      end else if (!empty) begin
         d_pc    = head.pc;
         d_instr = head.instr;
      end
   end

   assign d_pc_off  = d_pc - PC_BASE;
   assign occupancy = occ;

endmodule

// File: tb/tb_fd_fetch_queue.sv
// Bench for fd_fetch_queue: fetch model plus queue-based scoreboard with a decoupled head monitor.
module tb_fd_fetch_queue;
   import fd_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h00003000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        d_ready = 1'b0;
   logic [31:0] f_pc = BASE;
   logic [31:0] f_instr = 32'h0;
   logic        pc_wr_en, d_valid;
   logic [31:0] d_pc, d_instr, d_pc_off;
   logic [2:0]  occupancy;

   int tests = 0;
   int fails = 0;
   int cnt   = 0;
   fq_entry_t exp_q[$];

   fd_fetch_queue #(.DEPTH(DEPTH), .PC_BASE(BASE)) dut (
      .clk       (clk),
      .reset     (reset),
      .f_pc      (f_pc),
      .f_instr   (f_instr),
      .pc_wr_en  (pc_wr_en),
      .flush     (flush),
      .d_valid   (d_valid),
      .d_ready   (d_ready),
      .d_pc      (d_pc),
      .d_instr   (d_instr),
      .d_pc_off  (d_pc_off),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock of stimulus; the model is a plain list of entries held by the queue.
   task automatic step(input logic rst, input logic fl, input logic rdy, input logic [31:0] tgt);
      logic pwe;
      logic dq;
      @(negedge clk);
      #1;
      reset   = rst;
      flush   = fl;
      d_ready = rdy;
      #1;
      pwe = (cnt != DEPTH) || fl;
      if (rst) begin
         exp_q.delete();
         cnt = 0;
      end else begin
         chk("pc_wr_en", 32'(pc_wr_en), 32'(pwe));
         chk("occupancy", 32'(occupancy), cnt);
         chk("d_valid", 32'(d_valid), 32'(cnt != 0));
         if (cnt == 0) begin
            chk("empty_d_instr", d_instr, NOP_INSTR);
            chk("empty_d_pc", d_pc, 32'h0);
         end
         if (fl) begin
            exp_q.delete();
            cnt = 0;
         end else begin
            dq = (cnt > 0) && rdy;
            if (pwe) exp_q.push_back('{pc: f_pc, instr: f_instr});
            cnt = cnt + int'(pwe) - int'(dq);
         end
      end
      @(posedge clk);
      #1;
      if (rst) begin
         f_pc    = BASE;
         f_instr = $urandom;
      end else if (pwe) begin
         f_pc    = fl ? tgt : f_pc + 32'd4;
         f_instr = $urandom;
      end
   endtask

   // Head monitor: every accepted head must be the oldest entry still owed to decode.
   initial begin
      fq_entry_t e;
      forever begin
         @(negedge clk);
         #3;
         if (!reset && !flush && d_valid && d_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_head: got pc %h expected no entry", d_pc);
            end else begin
               e = exp_q.pop_front();
               chk("d_pc", d_pc, e.pc);
               chk("d_instr", d_instr, e.instr);
               chk("d_pc_off", d_pc_off, e.pc - BASE);
            end
         end
      end
   end

   initial begin
      f_instr = $urandom;
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
      // Streaming with decode always ready
      repeat (4) step(1'b0, 1'b0, 1'b1, 32'h0);
      // Fill until fetch stalls, then drain
      repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);
      repeat (3) step(1'b0, 1'b0, 1'b1, 32'h0);
      // Pointer wrap over many enq/deq pairs
      repeat (12) step(1'b0, 1'b0, 1'b1, 32'h0);
      // Flush with three held entries, redirect to 0x3100
      step(1'b1, 1'b0, 1'b0, 32'h0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 32'h00003100);
      repeat (4) step(1'b0, 1'b0, 1'b1, 32'h0);
      // Reset mid-stream with decode ready
      step(1'b1, 1'b0, 1'b0, 32'h0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h0);
      repeat (3) step(1'b0, 1'b0, 1'b1, 32'h0);
      // Randomized traffic with occasional flush and reset
      repeat (2000) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) < 6,
              BASE + (32'($urandom_range(0, 1023)) << 2));
      end
      @(negedge clk);
      #1;
      d_ready = 1'b0;
      @(negedge clk);
      #5;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
